note_sequencer: RTL and testbench

- Plays a programmable melody by driving the 16-bit frequency word into the tone/FM generator (`freq_i` of the existing oscillator) and a gate for downstream envelope/mute logic.
- Holds a small note table (frequency word, duration in ms, last flag) that is writable at runtime.
- Steps through the table with ms-accurate timing derived from the 12.5 MHz clock via the 48 kHz sample divider, with optional inter-note gap and looping.

---
 rtl/synth_seq_pkg.sv | 27 ++
 rtl/note_sequencer_tick_gen.sv | 50 +++++
 rtl/note_sequencer.sv | 177 +++++++++++++++++
 tb/tb_note_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_seq_pkg.sv
// Shared types and default constants for the note sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package synth_seq_pkg;

    // 12.5 MHz / 260 = 48.077 kHz sample rate; 48 samples make one duration unit
    localparam int          DIV_48KHZ      = 259;
    localparam int          SAMPLES_PER_MS = 48;
    localparam logic [15:0] FREQ_440HZ     = 16'd4723;

    typedef struct packed {
        logic [15:0] freq;
        logic [7:0]  dur;
        logic        last;
    } note_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        PLAY,
        GAP,
        NEXT,
        END
    } seq_state_t;

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// Sample-rate and millisecond strobe generator with synchronous clear.
// Latency: ticks are combinational from the counters; first sample_tick DIV_48KHZ cycles after clear.
// Backpressure: none; free-running except when cleared.
//
// Ports:
//   clk_i, rstn_i   clock and asynchronous active-low reset
//   clr_i           synchronous clear of both counters
//   sample_tick_o   one-cycle strobe every DIV_48KHZ+1 clocks
//   ms_tick_o       one-cycle strobe every SAMPLES_PER_MS samples
module seq_tick_gen #(
    parameter int DIV_48KHZ      = 259,
    parameter int SAMPLES_PER_MS = 48
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    output logic sample_tick_o,
    output logic ms_tick_o
);

    localparam int SW = (DIV_48KHZ > 0)      ? $clog2(DIV_48KHZ + 1) : 1;
    localparam int MW = (SAMPLES_PER_MS > 1) ? $clog2(SAMPLES_PER_MS) : 1;

    logic [SW-1:0] r_sample_cnt;
    logic [MW-1:0] r_ms_cnt;
    logic          w_sample_tick;
    logic          w_ms_last;

    assign w_sample_tick = (r_sample_cnt == SW'(DIV_48KHZ));
    assign w_ms_last     = (r_ms_cnt == MW'(SAMPLES_PER_MS - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sample_cnt <= '0;
            r_ms_cnt     <= '0;
        end else if (clr_i) begin
            r_sample_cnt <= '0;
            r_ms_cnt     <= '0;
        end else if (w_sample_tick) begin
            r_sample_cnt <= '0;
            r_ms_cnt     <= w_ms_last ? '0 : r_ms_cnt + MW'(1);
        end else begin
            r_sample_cnt <= r_sample_cnt + SW'(1);
        end
    end

    assign sample_tick_o = w_sample_tick;
    assign ms_tick_o     = w_sample_tick & w_ms_last;

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: walks a runtime-writable note table, driving oscillator frequency and gate.
// Latency: start to first gate = 3 cycles; gate high dur*(DIV_48KHZ+1)*SAMPLES_PER_MS clocks per note.
// Backpressure: none; start ignored while busy, stop aborts immediately, writes always accepted.
//
// Ports:
//   clk_i, rstn_i                         clock and asynchronous active-low reset
//   wr_en_i/addr/freq/dur/last            note table write port (dur 0 = end marker)
//   start_i, stop_i                       single-cycle control pulses; stop wins
//   loop_i                                level, restart from entry 0 at sequence end
//   freq_o, gate_o                        oscillator frequency word and note gate
//   note_idx_o, busy_o, done_o            current entry, non-idle flag, natural-end pulse
module note_sequencer #(
    parameter int DEPTH          = 16,
    parameter int DIV_48KHZ      = synth_seq_pkg::DIV_48KHZ,
    parameter int SAMPLES_PER_MS = synth_seq_pkg::SAMPLES_PER_MS,
    parameter int GAP_MS         = 1
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [15:0]              wr_freq_i,
    input  logic [7:0]               wr_dur_i,
    input  logic                     wr_last_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
    output logic [15:0]              freq_o,
    output logic                     gate_o,
    output logic [$clog2(DEPTH)-1:0] note_idx_o,
    output logic                     busy_o,
    output logic                     done_o
);

    import synth_seq_pkg::*;

    localparam int AW = $clog2(DEPTH);

    seq_state_t    r_state, w_nxt_state;
    note_entry_t   r_mem [DEPTH];
    note_entry_t   r_entry;
    logic [AW-1:0] r_idx, w_nxt_idx;
    logic [7:0]    r_cnt, w_nxt_cnt;
    logic [15:0]   r_freq, w_nxt_freq;
    logic          r_gate, r_busy, r_done;
    logic          w_nxt_done;
    logic          w_tick_clr;
    logic          w_sample_tick, w_ms_tick, w_unit_tick;

    seq_tick_gen #(
        .DIV_48KHZ      (DIV_48KHZ),
        .SAMPLES_PER_MS (SAMPLES_PER_MS)
    ) u_tick (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .clr_i         (w_tick_clr),
        .sample_tick_o (w_sample_tick),
        .ms_tick_o     (w_ms_tick)
    );

    assign w_unit_tick = w_sample_tick & w_ms_tick;

    // Table is not reset. The entry is read only in LOAD, so a write to the
    // entry currently playing is seen on its next LOAD, never mid-note.
    always_ff @(posedge clk_i) begin
        if (wr_en_i)
            r_mem[wr_addr_i] <= {wr_freq_i, wr_dur_i, wr_last_i};
        if (r_state == LOAD)
            r_entry <= r_mem[r_idx];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_freq  <= '0;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
            r_freq  <= w_nxt_freq;
            r_gate  <= (w_nxt_state == PLAY);
            r_busy  <= (w_nxt_state != IDLE);
            r_done  <= w_nxt_done;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt;
        w_nxt_freq  = r_freq;
        w_nxt_done  = 1'b0;
        w_tick_clr  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i && !stop_i) begin
                    w_nxt_state = LOAD;
                    w_nxt_idx   = '0;
                end
            end
            LOAD: w_nxt_state = FETCH;
            FETCH: begin
                if (r_entry.dur == 8'd0) begin
                    w_nxt_state = END;
                end else begin
                    w_nxt_freq  = r_entry.freq;
                    w_nxt_cnt   = r_entry.dur;
                    w_nxt_state = PLAY;
                    // Restart the prescaler so the note lasts whole ms units exactly
                    w_tick_clr  = 1'b1;
                end
            end
            PLAY: begin
                if (w_unit_tick) begin
                    w_nxt_cnt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        if (GAP_MS > 0) begin
                            w_nxt_state = GAP;
                            w_nxt_cnt   = 8'(GAP_MS);
                            w_tick_clr  = 1'b1;
                        end else begin
                            w_nxt_state = NEXT;
                        end
                    end
                end
            end
            GAP: begin
                if (w_unit_tick) begin
                    w_nxt_cnt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1)
                        w_nxt_state = NEXT;
                end
            end
            NEXT: begin
                if (r_entry.last || (r_idx == AW'(DEPTH - 1))) begin
                    w_nxt_state = END;
                end else begin
                    w_nxt_idx   = r_idx + AW'(1);
                    w_nxt_state = LOAD;
                end
            end
            END: begin
                if (loop_i) begin
                    w_nxt_idx   = '0;
                    w_nxt_state = LOAD;
                end else begin
                    w_nxt_done  = 1'b1;
                    w_nxt_freq  = '0;
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase

        // Abort overrides every other transition
        if (stop_i && (r_state != IDLE)) begin
            w_nxt_state = IDLE;
            w_nxt_idx   = '0;
            w_nxt_freq  = '0;
            w_nxt_done  = 1'b0;
            w_tick_clr  = 1'b0;
        end
    end

    assign freq_o     = r_freq;
    assign gate_o     = r_gate;
    assign note_idx_o = r_idx;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a shortened prescaler (16 clocks per ms).
// Latency: n/a.
// Backpressure: n/a.
module tb_note_sequencer;

    localparam int DEPTH  = 16;
    localparam int DIV    = 3;
    localparam int SPM    = 4;
    localparam int GAP_MS = 1;
    localparam int MSC    = (DIV + 1) * SPM;
    localparam int GAPC   = GAP_MS * MSC;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [3:0]  wr_addr_i = '0;
    logic [15:0] wr_freq_i = '0;
    logic [7:0]  wr_dur_i = '0;
    logic        wr_last_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        loop_i = 1'b0;
    logic [15:0] freq_o;
    logic        gate_o;
    logic [3:0]  note_idx_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    note_sequencer #(
        .DEPTH(DEPTH), .DIV_48KHZ(DIV), .SAMPLES_PER_MS(SPM), .GAP_MS(GAP_MS)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_freq_i(wr_freq_i),
        .wr_dur_i(wr_dur_i), .wr_last_i(wr_last_i),
        .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
        .freq_o(freq_o), .gate_o(gate_o), .note_idx_o(note_idx_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct {
        logic [15:0] freq;
        logic [7:0]  dur;
        int          exp_gate;
        int          exp_done_k;
    } vec_t;

    typedef struct packed {
        logic [15:0] freq;
        logic        gate;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
    } exp_t;

    logic [15:0] m_freq [DEPTH];
    logic [7:0]  m_dur  [DEPTH];
    logic        m_last [DEPTH];
    exp_t        trace[$];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] f, input logic [7:0] d, input logic l);
        wr_en_i = 1'b1; wr_addr_i = 4'(a); wr_freq_i = f; wr_dur_i = d; wr_last_i = l;
        step();
        wr_en_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int t = 0; t < 8000 && busy_o; t++) step();
        chk({nm, "_idle"}, busy_o, 0);
        step();
    endtask

    // Samples from the start edge (k=0) until the done pulse.
    task automatic measure(input logic [15:0] f, output int gate_cnt, output int done_k,
                           output int freq_bad);
        gate_cnt = 0; done_k = -1; freq_bad = 0;
        for (int k = 0; k < 6000; k++) begin
            if (gate_o) begin
                gate_cnt++;
                if (freq_o !== f) freq_bad++;
            end
            if (done_o) begin
                done_k = k;
                break;
            end
            step();
        end
    endtask

    task automatic push_n(input exp_t e, input int n);
        for (int j = 0; j < n; j++) trace.push_back(e);
    endtask

    // Expected per-cycle waveform built from per-note timing arithmetic:
    // 2 cycles to read an entry, dur ms of gate, GAP_MS ms of silence plus one
    // advance cycle, one cycle to finish, then the done pulse in idle.
    task automatic build_trace();
        logic [15:0] fprev;
        int          last_i;
        trace.delete();
        fprev  = 16'h0;
        last_i = 0;
        for (int i = 0; i < DEPTH; i++) begin
            last_i = i;
            push_n('{fprev, 1'b0, 4'(i), 1'b1, 1'b0}, 2);
            if (m_dur[i] == 8'd0) begin
                push_n('{fprev, 1'b0, 4'(i), 1'b1, 1'b0}, 1);
                break;
            end
            push_n('{m_freq[i], 1'b1, 4'(i), 1'b1, 1'b0}, int'(m_dur[i]) * MSC);
            push_n('{m_freq[i], 1'b0, 4'(i), 1'b1, 1'b0}, GAPC + 1);
            fprev = m_freq[i];
            if (m_last[i] || i == DEPTH - 1) begin
                push_n('{fprev, 1'b0, 4'(i), 1'b1, 1'b0}, 1);
                break;
            end
        end
        push_n('{16'h0, 1'b0, 4'(last_i), 1'b0, 1'b1}, 1);
        push_n('{16'h0, 1'b0, 4'(last_i), 1'b0, 1'b0}, 1);
    endtask

    task automatic run_trace(input string nm);
        int   bad_k;
        exp_t got, bad_got, bad_exp;
        for (int a = 0; a < DEPTH; a++) wr(a, m_freq[a], m_dur[a], m_last[a]);
        build_trace();
        bad_k = -1;
        bad_got = '0;
        bad_exp = '0;
        pulse_start();
        for (int k = 0; k < trace.size(); k++) begin
            got = '{freq_o, gate_o, note_idx_o, busy_o, done_o};
            if (bad_k < 0 && got !== trace[k]) begin
                bad_k = k; bad_got = got; bad_exp = trace[k];
            end
            if (k < trace.size() - 1) step();
        end
        n_cmp++;
        if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL %s: cycle %0d got freq=%0d gate=%0d idx=%0d busy=%0d done=%0d, required freq=%0d gate=%0d idx=%0d busy=%0d done=%0d",
                     nm, bad_k, bad_got.freq, bad_got.gate, bad_got.idx, bad_got.busy, bad_got.done,
                     bad_exp.freq, bad_exp.gate, bad_exp.idx, bad_exp.busy, bad_exp.done);
        end
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   g, d, fb, cnt, wraps, early, dropped, prev;

        // Single-note vectors: {freq, dur, gate clocks, done cycle after start}
        vecs[0] = '{synth_seq_pkg::FREQ_440HZ, 8'd2, 32, 52};
        vecs[1] = '{16'd9446, 8'd1, 16, 36};
        vecs[2] = '{16'h0001, 8'd0, 0, 3};
        vecs[3] = '{16'hFFFF, 8'd3, 48, 68};
        vecs[4] = '{16'h1234, 8'd255, 4080, 4100};
        vecs[5] = '{16'd2361, 8'd5, 80, 100};

        // Reset state
        step(); step();
        chk("rst_freq", freq_o, 0);
        chk("rst_gate", gate_o, 0);
        chk("rst_idx", note_idx_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rstn_i = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            wr(0, vecs[v].freq, vecs[v].dur, 1'b1);
            pulse_start();
            measure(vecs[v].freq, g, d, fb);
            chk($sformatf("vec%0d_gate_clks", v), g, vecs[v].exp_gate);
            chk($sformatf("vec%0d_done_k", v), d, vecs[v].exp_done_k);
            chk($sformatf("vec%0d_freq_bad", v), fb, 0);
            chk($sformatf("vec%0d_end_busy", v), busy_o, 0);
            chk($sformatf("vec%0d_end_freq", v), freq_o, 0);
            step();
            chk($sformatf("vec%0d_done_pulse", v), done_o, 0);
        end

        // Three-entry walk
        for (int a = 0; a < DEPTH; a++) begin
            m_freq[a] = 16'(a * 7 + 3); m_dur[a] = 8'd1; m_last[a] = 1'b0;
        end
        m_freq[0] = 16'd4723; m_freq[1] = 16'd9446; m_freq[2] = 16'd2361; m_last[2] = 1'b1;
        run_trace("walk3");

        // Full table with no last flag ends after the final index
        for (int a = 0; a < DEPTH; a++) begin
            m_freq[a] = 16'(a * 100 + 1); m_dur[a] = 8'd1; m_last[a] = 1'b0;
        end
        run_trace("table_full");

        // Loop for three passes, drop loop during the last note of pass three
        wr(0, 16'd4723, 8'd1, 1'b0); wr(1, 16'd9446, 8'd1, 1'b0); wr(2, 16'd2361, 8'd1, 1'b1);
        loop_i = 1'b1;
        pulse_start();
        wraps = 0; early = 0; dropped = 0; d = -1; prev = int'(note_idx_o);
        for (int k = 0; k < 3000; k++) begin
            step();
            if (prev == 2 && note_idx_o == 4'd0) wraps++;
            prev = int'(note_idx_o);
            if (done_o) begin
                if (dropped == 0) early++;
                else begin d = k; break; end
            end
            if (dropped == 0 && wraps == 2 && note_idx_o == 4'd2 && gate_o) begin
                loop_i = 1'b0; dropped = 1;
            end
        end
        loop_i = 1'b0;
        chk("loop_wraps", wraps, 2);
        chk("loop_no_early_done", early, 0);
        chk("loop_done_seen", (d >= 0), 1);
        wait_idle("loop");

        // Stop in the middle of the second note
        wr(0, 16'd4723, 8'd1, 1'b0); wr(1, 16'd9446, 8'd8, 1'b1);
        pulse_start();
        for (int t = 0; t < 200 && !(note_idx_o == 4'd1 && gate_o); t++) step();
        chk("stop_reach_note1", gate_o, 1);
        repeat (50) step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("stop_gate", gate_o, 0);
        chk("stop_freq", freq_o, 0);
        chk("stop_busy", busy_o, 0);
        chk("stop_idx", note_idx_o, 0);
        cnt = int'(done_o);
        repeat (40) begin step(); cnt += int'(done_o); end
        chk("stop_no_done", cnt, 0);
        pulse_start();
        for (int t = 0; t < 20 && !gate_o; t++) step();
        chk("restart_freq", freq_o, 4723);
        cnt = 0;
        for (int t = 0; t < 400 && gate_o; t++) begin cnt++; step(); end
        chk("restart_gate_clks", cnt, MSC);
        wait_idle("restart");

        // start together with stop in idle
        start_i = 1'b1; stop_i = 1'b1;
        step();
        start_i = 1'b0; stop_i = 1'b0;
        chk("startstop_busy", busy_o, 0);
        step(); step(); step();
        chk("startstop_gate", gate_o, 0);

        // start while busy is ignored
        wr(0, 16'd4723, 8'd2, 1'b1);
        pulse_start();
        d = -1; g = 0;
        for (int k = 0; k < 500; k++) begin
            if (gate_o) g++;
            if (done_o) begin d = k; break; end
            start_i = (k == 10);
            step();
        end
        start_i = 1'b0;
        chk("busy_start_gate", g, 32);
        chk("busy_start_done_k", d, 52);
        step();

        // Overwrite entry 1 while entry 0 plays
        wr(0, 16'd100, 8'd2, 1'b0); wr(1, 16'd200, 8'd1, 1'b1);
        pulse_start();
        for (int t = 0; t < 20 && !gate_o; t++) step();
        wr(1, 16'd300, 8'd1, 1'b1);
        for (int t = 0; t < 200 && !(note_idx_o == 4'd1 && gate_o); t++) step();
        chk("wr_play_freq", freq_o, 300);
        wait_idle("wr_play");

        // Asynchronous reset mid-note; table survives
        wr(0, 16'd100, 8'd1, 1'b0); wr(1, 16'd200, 8'd2, 1'b1);
        pulse_start();
        for (int t = 0; t < 200 && !(note_idx_o == 4'd1 && gate_o); t++) step();
        chk("arst_reach_note1", freq_o, 200);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_freq", freq_o, 0);
        chk("arst_gate", gate_o, 0);
        chk("arst_idx", note_idx_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        #3 rstn_i = 1'b1;
        step();
        chk("arst_idle", busy_o, 0);
        pulse_start();
        for (int t = 0; t < 20 && !gate_o; t++) step();
        chk("arst_table_kept", freq_o, 100);
        wait_idle("arst");

        // Randomized tables against the timing model
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_freq[a] = 16'($urandom);
                m_dur[a]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
                m_last[a] = ($urandom_range(0, 4) == 0);
            end
            run_trace($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
